// File: rtl/framebuffer_sink.sv
// framebuffer_sink: queues pixel plot strobes in a small FIFO, commits them to an on-chip
// framebuffer and streams that framebuffer back out as a raster. Optional clipping: FRAMEBUFFER_CLIP_EN.
module framebuffer_sink #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int COLOUR_BITS = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   plot,
    input  logic [7:0]             x,
    input  logic [6:0]             y,
    input  logic [COLOUR_BITS-1:0] colour,
    output logic                   write_ready,
    output logic                   overflow,
    output logic [7:0]             clip_count,
    output logic                   pix_valid,
    output logic [7:0]             pix_x,
    output logic [6:0]             pix_y,
    output logic [COLOUR_BITS-1:0] pix_colour,
    output logic                   line_start,
    output logic                   frame_start
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = 15;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_phase;
    logic [AW-1:0]          r_clr_addr;
    logic [AW-1:0]          r_scan_addr;
    logic [7:0]             r_scan_x;
    logic [6:0]             r_scan_y;
    logic                   r_overflow;
    logic                   r_pix_valid;
    logic [7:0]             r_pix_x;
    logic [6:0]             r_pix_y;
    logic                   r_line_start;
    logic                   r_frame_start;
    logic [COLOUR_BITS-1:0] r_rd_data;
    logic [COLOUR_BITS-1:0] r_mem [0:NPIX-1];

    logic [AW-1:0]          r_fifo_addr [0:FIFO_DEPTH-1];
    logic [COLOUR_BITS-1:0] r_fifo_col  [0:FIFO_DEPTH-1];
    logic [PW-1:0]          r_wptr, r_rptr;
    logic [CW-1:0]          r_count;

    logic                   w_clip, w_push, w_pop, w_we;
    logic [AW-1:0]          w_addr, w_plot_addr;
    logic [COLOUR_BITS-1:0] w_wdata;

    // WIDTH=160 decomposes into two shifts, so the default build needs no multiplier.
    generate
        if (WIDTH == 160) begin : g_addr_shift
            assign w_plot_addr = (AW'(y) << 7) + (AW'(y) << 5) + AW'(x);
        end else begin : g_addr_mul
            assign w_plot_addr = AW'(y) * AW'(WIDTH) + AW'(x);
        end
    endgenerate

`ifdef FRAMEBUFFER_CLIP_EN
    logic [7:0] r_clip_count;

    assign w_clip     = (int'(x) >= WIDTH) || (int'(y) >= HEIGHT);
    assign clip_count = r_clip_count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_clip_count <= 8'd0;
        else if (plot && write_ready && w_clip && r_clip_count != 8'hFF)
            r_clip_count <= r_clip_count + 8'd1;
    end
`else
    assign w_clip     = 1'b0;
    assign clip_count = 8'd0;
`endif

    assign w_push = plot && write_ready && !w_clip;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_CLEAR;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        write_ready = 1'b0;
        w_pop       = 1'b0;
        w_we        = 1'b0;
        w_addr      = r_scan_addr;
        w_wdata     = '0;
        case (r_state)
            S_CLEAR: begin
                w_we   = 1'b1;
                w_addr = r_clr_addr;
                if (r_clr_addr == AW'(NPIX - 1))
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                write_ready = (r_count < CW'(FIFO_DEPTH));
                // Phase 1 owns the RAM port for FIFO drain; out-of-frame addresses are dropped here.
                if (r_phase) begin
                    w_pop   = (r_count != '0);
                    w_addr  = r_fifo_addr[r_rptr];
                    w_wdata = r_fifo_col[r_rptr];
                    w_we    = w_pop && (w_addr < AW'(NPIX));
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_we)
            r_mem[w_addr] <= w_wdata;
        r_rd_data <= r_mem[w_addr];
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= w_plot_addr;
            r_fifo_col[r_wptr]  <= colour;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_phase       <= 1'b0;
            r_clr_addr    <= '0;
            r_scan_addr   <= '0;
            r_scan_x      <= 8'd0;
            r_scan_y      <= 7'd0;
            r_overflow    <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= 8'd0;
            r_pix_y       <= 7'd0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_phase    <= 1'b0;
            r_clr_addr <= r_clr_addr + AW'(1);
        end else begin
            r_phase       <= ~r_phase;
            r_pix_valid   <= ~r_phase;
            r_line_start  <= ~r_phase && (r_scan_x == 8'd0);
            r_frame_start <= ~r_phase && (r_scan_x == 8'd0) && (r_scan_y == 7'd0);
            if (plot && !write_ready)
                r_overflow <= 1'b1;
            if (!r_phase) begin
                r_pix_x <= r_scan_x;
                r_pix_y <= r_scan_y;
                if (r_scan_x == 8'(WIDTH - 1)) begin
                    r_scan_x <= 8'd0;
                    if (r_scan_y == 7'(HEIGHT - 1)) begin
                        r_scan_y    <= 7'd0;
                        r_scan_addr <= '0;
                    end else begin
                        r_scan_y    <= r_scan_y + 7'd1;
                        r_scan_addr <= r_scan_addr + AW'(1);
                    end
                end else begin
                    r_scan_x    <= r_scan_x + 8'd1;
                    r_scan_addr <= r_scan_addr + AW'(1);
                end
            end
        end
    end

    assign overflow    = r_overflow;
    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_colour  = r_pix_valid ? r_rd_data : '0;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
endmodule

// File: tb/tb_framebuffer_sink.sv
// Directed bench for framebuffer_sink: clear length, raster stream, plot commit,
// FIFO overflow, clipping/aliasing, read-after-write ordering and mid-frame reset.
module tb_framebuffer_sink;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       plot = 1'b0;
    logic [7:0] x = 8'd0;
    logic [6:0] y = 7'd0;
    logic [2:0] colour = 3'd0;
    logic       write_ready, overflow, pix_valid, line_start, frame_start;
    logic [7:0] clip_count, pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_colour;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_pix = 0, n_ls = 0, n_fs = 0, n_nz = 0;
    int exp_clip, exp_nz;
    logic [2:0] exp_alias;
    logic [2:0] exp_burst [0:7];
    logic [2:0] seen [0:19199];

    framebuffer_sink dut (
        .clock(clock), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
        .write_ready(write_ready), .overflow(overflow), .clip_count(clip_count),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (pix_valid) begin
            int idx;
            idx = int'(pix_y) * 160 + int'(pix_x);
            n_pix++;
            if (line_start) n_ls++;
            if (frame_start) n_fs++;
            if (pix_colour != 3'd0) n_nz++;
            if (idx < 19200) seen[idx] = pix_colour;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic set_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        plot = 1'b1; x = px; y = py; colour = pc;
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (!write_ready && n < 20000) begin
            step();
            n++;
        end
        chk("clear_len", n, 19200);
        cyc = 0;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_write_ready"}, write_ready, 0);
        chk({p, "_overflow"}, overflow, 0);
        chk({p, "_clip_count"}, clip_count, 0);
        chk({p, "_pix_valid"}, pix_valid, 0);
        chk({p, "_pix_x"}, pix_x, 0);
        chk({p, "_pix_y"}, pix_y, 0);
        chk({p, "_pix_colour"}, pix_colour, 0);
        chk({p, "_line_start"}, line_start, 0);
        chk({p, "_frame_start"}, frame_start, 0);
    endtask

    task automatic zero_counts();
        n_pix = 0; n_ls = 0; n_fs = 0; n_nz = 0;
    endtask

    initial begin
`ifdef FRAMEBUFFER_CLIP_EN
        exp_clip = 2; exp_nz = 9; exp_alias = 3'd0;
`else
        exp_clip = 0; exp_nz = 10; exp_alias = 3'd3;
`endif
        exp_burst[0] = 3'd1; exp_burst[1] = 3'd2; exp_burst[2] = 3'd3; exp_burst[3] = 3'd4;
        exp_burst[4] = 3'd5; exp_burst[5] = 3'd6; exp_burst[6] = 3'd0; exp_burst[7] = 3'd1;

        repeat (3) @(negedge clock);
        chk_reset("rst");
        resetn = 1'b1;
        wait_clear();

        chk("run0_pix_valid", pix_valid, 0);
        zero_counts();
        step();
        chk("first_valid", pix_valid, 1);
        chk("first_frame_start", frame_start, 1);
        chk("first_line_start", line_start, 1);
        chk("first_x", pix_x, 0);
        chk("first_y", pix_y, 0);
        chk("first_colour", pix_colour, 0);

        // Plot (10,10) in the cycle just before its phase-0 read in frame 0.
        run_to(3219);
        chk("pre_raw_valid", pix_valid, 1);
        chk("pre_raw_x", pix_x, 9);
        chk("pre_raw_y", pix_y, 10);
        set_plot(8'd10, 7'd10, 3'd7);
        step();
        plot = 1'b0;
        step();
        chk("raw_valid", pix_valid, 1);
        chk("raw_x", pix_x, 10);
        chk("raw_y", pix_y, 10);
        chk("raw_old_colour", pix_colour, 0);

        run_to(7041);
        chk("single_phase1", pix_valid, 1);
        set_plot(8'd5, 7'd3, 3'b101);
        step();
        plot = 1'b0;
        run_to(7051);
        chk("burst_ready_before", write_ready, 1);
        chk("overflow_before", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 6) chk("burst_full_ready", write_ready, 0);
            set_plot(8'(20 + i), 7'd5, 3'((i % 7) + 1));
            step();
        end
        plot = 1'b0;
        chk("burst_overflow", overflow, 1);

        run_to(7081);
        set_plot(8'd160, 7'd0, 3'd3);
        step();
        set_plot(8'd0, 7'd120, 3'd6);
        step();
        plot = 1'b0;
        run_to(7091);
        chk("clip_count", clip_count, exp_clip);

        run_to(38400);
        chk("f0_end_valid", pix_valid, 0);
        chk("f0_pixels", n_pix, 19200);
        chk("f0_line_starts", n_ls, 120);
        chk("f0_frame_starts", n_fs, 1);
        chk("f0_nonzero", n_nz, 0);
        zero_counts();

        run_to(41920);
        chk("f1_pixels", n_pix, 1760);
        chk("f1_line_starts", n_ls, 11);
        chk("f1_frame_starts", n_fs, 1);
        chk("f1_nonzero", n_nz, exp_nz);
        chk("f1_raw_new", seen[10 * 160 + 10], 7);
        chk("f1_single", seen[3 * 160 + 5], 5);
        chk("f1_alias", seen[160], exp_alias);
        chk("f1_origin", seen[0], 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("f1_burst%0d", i), seen[5 * 160 + 20 + i], exp_burst[i]);

        // Leave two entries queued and one already committed, then reset mid-frame.
        set_plot(8'd40, 7'd2, 3'd7);
        step();
        set_plot(8'd41, 7'd2, 3'd7);
        step();
        set_plot(8'd42, 7'd2, 3'd7);
        step();
        plot = 1'b0;
        resetn = 1'b0;
        #1;
        chk_reset("midrst");
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        wait_clear();
        zero_counts();
        run_to(960);
        chk("post_pixels", n_pix, 480);
        chk("post_frame_starts", n_fs, 1);
        chk("post_nonzero", n_nz, 0);
        chk("post_blank_40_2", seen[2 * 160 + 40], 0);
        chk("post_blank_0_1", seen[160], 0);
        chk("post_overflow", overflow, 0);
        chk("post_clip_count", clip_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
